// File: rtl/axi_ram_burst.sv
// ============================================================================
// Module      : axi_ram_burst
// Description : AXI4 slave RAM with INCR/FIXED bursts, byte strobes and
//               B-channel completion. The read and write engines are
//               independent, and each holds one outstanding transaction.
//               Optional feature macro: AXI_RAM_WRAP_EN enables WRAP bursts
//               with len 1/3/7/15. Without it, WRAP bursts complete with
//               SLVERR.
// Ports       : aclk/aresetn         clock, async active-low reset
//               s_axi_aw*            write address channel (lock/cache/prot ignored)
//               s_axi_w*             write data channel
//               s_axi_b*             write response channel
//               s_axi_ar*            read address channel (lock/cache/prot ignored)
//               s_axi_r*             read data channel
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_ram_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int                    c_ADDR_LSB    = $clog2(STRB_WIDTH);
    localparam logic [2:0]            c_SIZE        = 3'(c_ADDR_LSB);
    localparam logic [1:0]            c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]            c_RESP_SLVERR = 2'b10;
    localparam logic [DEPTH_LOG2-1:0] c_ONE         = 1;

    // Address of the word that follows cur within a burst.
    function automatic logic [DEPTH_LOG2-1:0] next_word(
        input logic [DEPTH_LOG2-1:0] cur,
        input logic [1:0]            burst,
        input logic [7:0]            len
    );
        logic [DEPTH_LOG2-1:0] mask;
        mask      = DEPTH_LOG2'(len);
        next_word = cur;
        case (burst)
            2'b01:   next_word = cur + c_ONE;
`ifdef AXI_RAM_WRAP_EN
            // len+1 is a power of two, so len is the in-window offset mask.
            2'b10:   next_word = (cur & ~mask) | ((cur + c_ONE) & mask);
`endif
            default: next_word = cur | (mask & '0);
        endcase
    endfunction

    // Transactions the RAM refuses to service: they still run to their
    // beat count but never touch the array and return zero data.
    function automatic logic txn_err(
        input logic [2:0] size,
        input logic [1:0] burst,
        input logic [7:0] len
    );
        txn_err = (size != c_SIZE) || (burst == 2'b11);
`ifdef AXI_RAM_WRAP_EN
        if (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            txn_err = 1'b1;
`else
        if (burst == 2'b10 || (len & 8'd0) != 8'd0)
            txn_err = 1'b1;
`endif
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [0:(1 << DEPTH_LOG2)-1];

    logic w_unused;
    assign w_unused = &{1'b0, s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awaddr,
                        s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_araddr};

    // ------------------------------------------------------------------ write
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;

    wstate_t               r_wstate, w_wstate_nxt;
    logic [ID_WIDTH-1:0]   r_awid;
    logic [DEPTH_LOG2-1:0] r_waddr;
    logic [7:0]            r_wlen, r_wcnt;
    logic [1:0]            r_wburst;
    logic                  r_werr, r_wlast_err;
    logic                  w_wbeat, w_wfinal;

    assign w_wbeat  = s_axi_wvalid && s_axi_wready;
    assign w_wfinal = (r_wcnt == r_wlen);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_wstate <= W_IDLE;
        else          r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt  = r_wstate;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && w_wfinal) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_awid      <= '0;
            r_waddr     <= '0;
            r_wlen      <= '0;
            r_wcnt      <= '0;
            r_wburst    <= '0;
            r_werr      <= 1'b0;
            r_wlast_err <= 1'b0;
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                r_awid      <= s_axi_awid;
                r_waddr     <= s_axi_awaddr[c_ADDR_LSB +: DEPTH_LOG2];
                r_wlen      <= s_axi_awlen;
                r_wcnt      <= '0;
                r_wburst    <= s_axi_awburst;
                r_werr      <= txn_err(s_axi_awsize, s_axi_awburst, s_axi_awlen);
                r_wlast_err <= 1'b0;
            end
            if (w_wbeat) begin
                r_wcnt  <= r_wcnt + 8'd1;
                r_waddr <= next_word(r_waddr, r_wburst, r_wlen);
                // Beat count, not wlast, terminates the burst.
                if (s_axi_wlast != w_wfinal) r_wlast_err <= 1'b1;
            end
        end
    end

    assign s_axi_bid   = r_awid;
    assign s_axi_bresp = (r_werr || r_wlast_err) ? c_RESP_SLVERR : c_RESP_OKAY;

    always_ff @(posedge aclk) begin
        if (w_wbeat && !r_werr) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) r_mem[r_waddr][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------- read
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    rstate_t               r_rstate, w_rstate_nxt;
    logic [ID_WIDTH-1:0]   r_arid;
    logic [DEPTH_LOG2-1:0] r_raddr;  // word to load on the next accepted beat
    logic [DEPTH_LOG2-1:0] w_ar_word;
    logic [7:0]            r_rlen, r_rcnt;
    logic [1:0]            r_rburst;
    logic                  r_rerr, w_ar_err;
    logic [DATA_WIDTH-1:0] r_rdata;

    assign w_ar_word = s_axi_araddr[c_ADDR_LSB +: DEPTH_LOG2];
    assign w_ar_err  = txn_err(s_axi_arsize, s_axi_arburst, s_axi_arlen);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_rstate <= R_IDLE;
        else          r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt  = r_rstate;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = (r_rcnt == r_rlen);
                if (s_axi_rready && s_axi_rlast) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Array reads use the pre-edge contents, so a same-cycle write to the
    // same word is seen only by later reads.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_arid   <= '0;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_rburst <= '0;
            r_rerr   <= 1'b0;
            r_rdata  <= '0;
        end else if (s_axi_arvalid && s_axi_arready) begin
            r_arid   <= s_axi_arid;
            r_raddr  <= next_word(w_ar_word, s_axi_arburst, s_axi_arlen);
            r_rlen   <= s_axi_arlen;
            r_rcnt   <= '0;
            r_rburst <= s_axi_arburst;
            r_rerr   <= w_ar_err;
            r_rdata  <= w_ar_err ? '0 : r_mem[w_ar_word];
        end else if (s_axi_rvalid && s_axi_rready && !s_axi_rlast) begin
            r_rcnt  <= r_rcnt + 8'd1;
            r_raddr <= next_word(r_raddr, r_rburst, r_rlen);
            r_rdata <= r_rerr ? '0 : r_mem[r_raddr];
        end
    end

    assign s_axi_rid   = r_arid;
    assign s_axi_rdata = r_rdata;
    assign s_axi_rresp = r_rerr ? c_RESP_SLVERR : c_RESP_OKAY;

endmodule

`default_nettype wire

// File: tb/tb_axi_ram_burst.sv
// ============================================================================
// Module      : tb_axi_ram_burst
// Description : Self-checking bench for axi_ram_burst. Directed steps plus
//               randomized bursts checked against an array model of the RAM.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi_ram_burst;

    localparam int DEPTH = 1024;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  s_axi_awid = '0, s_axi_arid = '0;
    logic [15:0] s_axi_awaddr = '0, s_axi_araddr = '0;
    logic [7:0]  s_axi_awlen = '0, s_axi_arlen = '0;
    logic [2:0]  s_axi_awsize = 3'd2, s_axi_arsize = 3'd2;
    logic [1:0]  s_axi_awburst = 2'b01, s_axi_arburst = 2'b01;
    logic        s_axi_awvalid = 1'b0, s_axi_arvalid = 1'b0;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0;
    logic        s_axi_bready = 1'b0, s_axi_rready = 1'b0;
    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready;
    logic        s_axi_rvalid, s_axi_rlast;
    logic [7:0]  s_axi_bid, s_axi_rid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;

    int tests = 0;
    int fails = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] wdat [256];
    logic [3:0]  wstb [256];

    always #5 aclk = ~aclk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    axi_ram_burst dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0),
        .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
        .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rules: which transactions are serviced, and which word each beat touches.
    function automatic bit legal(input int size, input int burst, input int len);
        if (size != 2 || burst == 3) return 1'b0;
        if (burst == 2) begin
`ifdef AXI_RAM_WRAP_EN
            return (len == 1 || len == 3 || len == 7 || len == 15);
`else
            return 1'b0;
`endif
        end
        return 1'b1;
    endfunction

    function automatic int beat_idx(input int addr, input int burst, input int len, input int i);
        int base, n;
        base = (addr / 4) % DEPTH;
        n    = len + 1;
        if (burst == 1) return (base + i) % DEPTH;
        if (burst == 2) return (base / n) * n + ((base % n) + i) % n;
        return base;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input int addr, input int len, input int burst, input int size,
                            input int last_at, input string tag);
        int n;
        logic [7:0] id;
        logic [31:0] w;
        id = 8'($urandom);
        s_axi_awid = id; s_axi_awaddr = 16'(addr); s_axi_awlen = 8'(len);
        s_axi_awburst = 2'(burst); s_axi_awsize = 3'(size); s_axi_awvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 50) begin tick(); n++; end
        if (!s_axi_awready) check({tag, " awready timeout"}, s_axi_awready, 1);
        tick();
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            s_axi_wdata = wdat[i]; s_axi_wstrb = wstb[i];
            s_axi_wlast = (i == last_at); s_axi_wvalid = 1'b1;
            n = 0;
            while (!s_axi_wready && n < 50) begin tick(); n++; end
            if (!s_axi_wready) check({tag, " wready timeout"}, s_axi_wready, 1);
            tick();
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        check({tag, " bvalid"}, s_axi_bvalid, 1);
        check({tag, " bid"}, s_axi_bid, id);
        check({tag, " bresp"}, s_axi_bresp,
              (legal(size, burst, len) && last_at == len) ? 2'b00 : 2'b10);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check({tag, " awready after B"}, s_axi_awready, 1);
        if (legal(size, burst, len)) begin
            for (int i = 0; i <= len; i++) begin
                w = model_mem[beat_idx(addr, burst, len, i)];
                for (int b = 0; b < 4; b++)
                    if (wstb[i][b]) w[b*8 +: 8] = wdat[i][b*8 +: 8];
                model_mem[beat_idx(addr, burst, len, i)] = w;
            end
        end
    endtask

    // mode 0: rready always high, 1: toggles 1/0, 2: random
    task automatic do_read(input int addr, input int len, input int burst, input int size,
                           input int mode, input string tag);
        int n, k;
        bit stalled;
        logic [7:0] id;
        logic [31:0] held, exp;
        id = 8'($urandom);
        s_axi_arid = id; s_axi_araddr = 16'(addr); s_axi_arlen = 8'(len);
        s_axi_arburst = 2'(burst); s_axi_arsize = 3'(size); s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 50) begin tick(); n++; end
        if (!s_axi_arready) check({tag, " arready timeout"}, s_axi_arready, 1);
        tick();
        s_axi_arvalid = 1'b0;
        check({tag, " rvalid latency"}, s_axi_rvalid, 1);
        k = 0; n = 0; stalled = 1'b0; held = '0;
        while (k <= len && n < 1200) begin
            case (mode)
                0:       s_axi_rready = 1'b1;
                1:       s_axi_rready = (n % 2 == 0);
                default: s_axi_rready = 1'($urandom_range(0, 1));
            endcase
            if (stalled && s_axi_rvalid) check({tag, " rdata stable"}, s_axi_rdata, held);
            stalled = 1'b0;
            if (s_axi_rvalid) begin
                if (s_axi_rready) begin
                    exp = legal(size, burst, len) ? model_mem[beat_idx(addr, burst, len, k)] : 32'd0;
                    check($sformatf("%s rdata beat %0d", tag, k), s_axi_rdata, exp);
                    check($sformatf("%s rlast beat %0d", tag, k), s_axi_rlast, (k == len));
                    check({tag, " rid"}, s_axi_rid, id);
                    check({tag, " rresp"}, s_axi_rresp, legal(size, burst, len) ? 2'b00 : 2'b10);
                    k++;
                end else begin
                    held = s_axi_rdata;
                    stalled = 1'b1;
                end
            end
            tick();
            n++;
        end
        s_axi_rready = 1'b0;
        check({tag, " beats received"}, k, len + 1);
        check({tag, " rvalid after last"}, s_axi_rvalid, 0);
    endtask

    initial begin
        int a, l, bu, sz, md;
        logic [31:0] old;

        // Reset values
        repeat (2) @(posedge aclk);
        #1;
        check("reset awready", s_axi_awready, 1);
        check("reset arready", s_axi_arready, 1);
        check("reset wready", s_axi_wready, 0);
        check("reset bvalid", s_axi_bvalid, 0);
        check("reset rvalid", s_axi_rvalid, 0);
        check("reset rlast", s_axi_rlast, 0);
        check("reset rdata", s_axi_rdata, 0);
        check("reset bid/rid", {s_axi_bid, s_axi_rid}, 0);
        check("reset bresp/rresp", {s_axi_bresp, s_axi_rresp}, 0);
        aresetn = 1'b1;
        tick();

        // Give every word a known value with four maximum-length bursts.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
            do_write(blk * 1024, 255, 1, 2, 255, "fill");
        end

        // Single-beat write then read
        wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
        do_write(16'h10, 0, 1, 2, 0, "t1 write");
        do_read(16'h10, 0, 1, 2, 0, "t2 read");
        check("t2 value", model_mem[4], 32'hDEADBEEF);
        do_read(16'h1010, 0, 1, 2, 0, "alias read");

        // INCR with partial strobe on beat 2
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
        wstb[2] = 4'h3;
        old = model_mem[2];
        do_write(0, 3, 1, 2, 3, "t3 write");
        check("t3 merged word", model_mem[2], {old[31:16], 16'h0003});
        do_read(0, 3, 1, 2, 0, "t3 read");

        // Eight-beat read under toggled rready
        do_read(16'h20, 7, 1, 2, 1, "t4 read");

        // Early wlast
        for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        do_write(16'h100, 3, 1, 2, 2, "t5 early wlast");
        do_write(16'h100, 3, 1, 2, -1, "t5 missing wlast");

        // WRAP burst at word 2
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + 32'(i); wstb[i] = 4'hF; end
        do_write(16'h8, 3, 2, 2, 3, "t6 wrap write");
        do_read(16'h8, 3, 2, 2, 0, "t6 wrap read");
        do_read(0, 3, 1, 2, 0, "t6 incr readback");

        // Unsupported size / reserved burst, modulo-depth INCR wrap, FIXED
        do_write(16'h40, 1, 1, 1, 1, "bad size write");
        do_read(16'h40, 1, 3, 2, 0, "reserved burst read");
        for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'(1 << i); end
        do_write(16'h0FF8, 3, 1, 2, 3, "depth wrap write");
        do_read(16'h0FF8, 3, 1, 2, 2, "depth wrap read");
        do_write(16'h60, 3, 0, 2, 3, "fixed write");
        do_read(16'h60, 3, 0, 2, 2, "fixed read");

        // Same word written and read on the same edge
        old = model_mem[8];
        s_axi_awaddr = 16'h20; s_axi_awlen = 0; s_axi_awburst = 2'b01; s_axi_awsize = 3'd2;
        s_axi_awid = 8'h11; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wdata = ~old; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        s_axi_araddr = 16'h20; s_axi_arlen = 0; s_axi_arburst = 2'b01; s_axi_arsize = 3'd2;
        s_axi_arid = 8'h22; s_axi_arvalid = 1'b1;
        check("rbw wready", s_axi_wready, 1);
        check("rbw arready", s_axi_arready, 1);
        tick();
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
        check("rbw old data", s_axi_rdata, old);
        check("rbw bvalid", s_axi_bvalid, 1);
        s_axi_rready = 1'b1; s_axi_bready = 1'b1;
        tick();
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;
        model_mem[8] = ~old;
        do_read(16'h20, 0, 1, 2, 0, "rbw new data");

        // Reset in the middle of a read burst
        s_axi_araddr = 16'h40; s_axi_arlen = 7; s_axi_arburst = 2'b01; s_axi_arsize = 3'd2;
        s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        repeat (3) tick();
        check("t7 rvalid before reset", s_axi_rvalid, 1);
        aresetn = 1'b0;
        #1;
        check("t7 rvalid in reset", s_axi_rvalid, 0);
        check("t7 arready in reset", s_axi_arready, 1);
        check("t7 rdata in reset", s_axi_rdata, 0);
        s_axi_rready = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        do_read(16'h40, 7, 1, 2, 0, "t7 data intact");

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            a  = int'($urandom_range(0, 16'hFFFF));
            bu = int'($urandom_range(0, 4));
            bu = (bu >= 3) ? 1 : bu;
            if ($urandom_range(0, 9) == 0) bu = 3;
            l  = (bu == 2) ? ((1 << $urandom_range(1, 4)) - 1) : int'($urandom_range(0, 15));
            if (bu == 2 && $urandom_range(0, 4) == 0) l = 2;
            sz = ($urandom_range(0, 9) == 0) ? 1 : 2;
            md = int'($urandom_range(0, 2));
            for (int i = 0; i <= l; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
            do_write(a, l, bu, sz, l, $sformatf("rand%0d write", t));
            do_read(a, l, bu, sz, md, $sformatf("rand%0d read", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
